div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states, default width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the remainder left, bring in the next
// dividend bit, and subtract the divisor when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, dvd_msb_i};
  assign diff    = shifted - {1'b0, dvs_i};

  // rem_i < dvs_i keeps shifted below 2*dvs_i, so the top bit of the
  // WIDTH+1-bit difference is a clean borrow flag.
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider and remainder unit: one quotient bit per
// cycle, with single-cycle handling of divide-by-zero and signed overflow.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             fast_q, fast_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  logic             in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_res, r_res;

  assign in_signed = ~op[0];
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;

  // The dividend register doubles as the quotient: bits shift out the top
  // into the step and quotient bits shift in at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Fast-path results are already final, so the sign fix-up is bypassed.
  assign q_res = (q_neg_q && !fast_q) ? -dvd_q : dvd_q;
  assign r_res = (r_neg_q && !fast_q) ? -rem_q : rem_q;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    fast_d  = fast_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dvs_d   = abs_b;
          cnt_d   = CNT_W'(WIDTH - 1);
          if (b == '0) begin
            fast_d  = 1'b1;
            dvd_d   = '1;
            rem_d   = a;
            state_d = FIX;
          end else if (in_signed && (a == MIN_VAL) && (b == '1)) begin
            fast_d  = 1'b1;
            dvd_d   = a;
            rem_d   = '0;
            state_d = FIX;
          end else begin
            fast_d  = 1'b0;
            dvd_d   = abs_a;
            rem_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        out_d   = op_q[1] ? r_res : q_res;
        zero_d  = (out_d == '0);
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: only control and visible outputs are reset; the datapath registers
  // are always loaded on an accepted start before they are read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
    op_q    <= op_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    fast_q  <= fast_d;
    dvd_q   <= dvd_d;
    dvs_q   <= dvs_d;
    rem_q   <= rem_d;
  end

  assign out  = out_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a behavioural model fills a scoreboard at each
// start, and entries are popped and compared when done pulses.
module tb_div_unit;

  localparam int W     = 64;
  localparam int LIMIT = 200;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero;
  logic [W-1:0] out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic sgn;
    logic is_rem;
    sgn    = ~o[0];
    is_rem = o[1];
    if (y == '0) return is_rem ? x : '1;
    if (sgn && x == MIN_VAL && y == '1) return is_rem ? '0 : x;
    if (sgn) return is_rem ? W'($signed(x) % $signed(y)) : W'($signed(x) / $signed(y));
    return is_rem ? (x % y) : (x / y);
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    if (y == '0) return 1;
    if (!o[0] && x == MIN_VAL && y == '1) return 1;
    return W + 1;
  endfunction

  // Issue one request at the next edge and wait for its done pulse. With noisy
  // set, start stays high and the operands change while the unit is busy.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit noisy);
    exp_t e;
    int   n;
    e.res = model(o, x, y);
    e.lat = model_lat(o, x, y);
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    if (noisy) begin
      a  = ~x;
      b  = y + 64'd5;
      op = o ^ 2'b01;
      check({tag, "_busy"}, W'(busy), W'(1'b1));
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_done"}, W'(done), W'(1'b1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, W'(n), W'(e.lat));
      check({tag, "_out"}, out, e.res);
      check({tag, "_zero"}, W'(zero), W'(e.res == '0));
    end
    tick();
    check({tag, "_idle"}, W'(busy), W'(1'b0));
  endtask

  initial begin
    tick();
    tick();
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_out", out, '0);
    check("rst_zero", W'(zero), W'(1'b1));
    rst = 1'b0;

    do_op("divu_100_7", 2'b01, 64'd100, 64'd7, 1'b0);
    do_op("div_m7_2",   2'b00, -64'sd7, 64'd2, 1'b0);
    do_op("rem_m7_2",   2'b10, -64'sd7, 64'd2, 1'b0);
    do_op("remu_7_7",   2'b11, 64'd7, 64'd7, 1'b0);
    do_op("div_by0",    2'b00, 64'd5, 64'd0, 1'b0);
    do_op("divu_by0",   2'b01, 64'd5, 64'd0, 1'b0);
    do_op("rem_by0",    2'b10, 64'd5, 64'd0, 1'b0);
    do_op("div_ovf",    2'b00, MIN_VAL, '1, 1'b0);
    do_op("rem_ovf",    2'b10, MIN_VAL, '1, 1'b0);
    do_op("divu_big",   2'b01, MIN_VAL, '1, 1'b0);
    do_op("rem_m100_m7", 2'b10, -64'sd100, -64'sd7, 1'b0);

    do_op("held_start", 2'b01, 64'd1000, 64'd10, 1'b1);
    do_op("after_held", 2'b01, 64'd77, 64'd3, 1'b0);

    // Abandon an operation partway through CALC; no result is expected.
    start = 1'b1; op = 2'b01; a = 64'd100; b = 64'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) check("abort_early_done", W'(done), W'(1'b0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", W'(busy), W'(1'b0));
    check("abort_done", W'(done), W'(1'b0));
    check("abort_out", out, '0);
    check("abort_zero", W'(zero), W'(1'b1));
    do_op("divu_9_3", 2'b01, 64'd9, 64'd3, 1'b0);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done === 1'b1) check("stray_done", W'(done), W'(1'b0));
    end
    check("sb_empty", W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
